// File: rtl/crc_pkg.sv
// Shared constants for the Bloom-filter CRC hashing blocks.
package crc_pkg;

  // Per-channel seeds for the default 4 x 13-bit configuration.
  // Channel k sits at bits [k*13 +: 13]; channel 0 is the least significant field.
  localparam logic [51:0] CRC_INITS = {13'h1A2B, 13'h0F0F, 13'h1FFF, 13'h0000};

endpackage

// File: rtl/crc_hash_stream_if.sv
// Byte stream in (valid/ready, sop/eop framing) and hash result out (valid/ready).
interface crc_hash_stream_if #(
  parameter int unsigned BYTE_W   = 8,
  parameter int unsigned WIDTH    = 13,
  parameter int unsigned HASH_CNT = 4,
  parameter int unsigned LEN_W    = 16
);
  logic [BYTE_W-1:0]         data_i;
  logic                      valid_i;
  logic                      sop_i;
  logic                      eop_i;
  logic                      ready_o;
  logic [HASH_CNT*WIDTH-1:0] res_o;
  logic [LEN_W-1:0]          len_o;
  logic                      res_valid_o;
  logic                      res_ready_i;
  logic                      err_o;

  // Hash engine side.
  modport slave (
    input  data_i, valid_i, sop_i, eop_i, res_ready_i,
    output ready_o, res_o, len_o, res_valid_o, err_o
  );

  // Byte producer / result consumer side.
  modport master (
    output data_i, valid_i, sop_i, eop_i, res_ready_i,
    input  ready_o, res_o, len_o, res_valid_o, err_o
  );
endinterface

// File: rtl/crc_hash_stream.sv
// Streaming multi-hash CRC engine: folds one byte per clock into HASH_CNT
// CRC accumulators (shared polynomial, per-channel seed) and hands the
// finished hashes plus the string length to the Bloom filter stage.
module crc_hash_stream #(
  parameter int unsigned               BYTE_W   = 8,
  parameter int unsigned               WIDTH    = 13,
  parameter int unsigned               HASH_CNT = 4,
  parameter logic [WIDTH-1:0]          POLY     = 13'h1CF5,
  parameter logic [HASH_CNT*WIDTH-1:0] INITS    = crc_pkg::CRC_INITS,
  parameter int unsigned               LEN_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  crc_hash_stream_if.slave s
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t                    state_q, state_d;
  logic [HASH_CNT*WIDTH-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [HASH_CNT*WIDTH-1:0] res_q;
  logic [LEN_W-1:0]          res_len_q;
  logic                      res_vld_q;
  logic                      err_q, err_d;
  logic                      load;
  logic                      ready;
  logic                      accept;

  // MSB-first, non-reflected CRC update over one whole input symbol.
  function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] c,
                                                input logic [BYTE_W-1:0] d);
    logic [WIDTH-1:0] r;
    logic             fb;
    r = c;
    for (int b = BYTE_W - 1; b >= 0; b--) begin
      fb = r[WIDTH-1] ^ d[b];
      r  = {r[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  // Length counter increment that sticks at all-ones.
  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] l);
    return (&l) ? l : l + 1'b1;
  endfunction

  // While an unaccepted result is held, every byte is stalled so the result
  // register never has to be overwritten.
  assign ready  = !res_vld_q || s.res_ready_i;
  assign accept = s.valid_i && ready;

  assign s.ready_o     = ready;
  assign s.res_o       = res_q;
  assign s.len_o       = res_len_q;
  assign s.res_valid_o = res_vld_q;
  assign s.err_o       = err_q;

  // Framing FSM and accumulator next-state; a sop always reseeds from INITS,
  // even mid-string, so a truncated string can never leak into the next one.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    load    = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      if (s.sop_i) begin
        for (int k = 0; k < HASH_CNT; k++) begin
          acc_d[k*WIDTH +: WIDTH] = crc_step(INITS[k*WIDTH +: WIDTH], s.data_i);
        end
        len_d = LEN_W'(1);
        err_d = (state_q == ACC);
        if (s.eop_i) begin
          load    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ACC;
        end
      end else if (state_q == ACC) begin
        for (int k = 0; k < HASH_CNT; k++) begin
          acc_d[k*WIDTH +: WIDTH] = crc_step(acc_q[k*WIDTH +: WIDTH], s.data_i);
        end
        len_d = len_sat_inc(len_q);
        if (s.eop_i) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end else begin
        // Continuation byte with no string open: drop it and flag.
        err_d = 1'b1;
      end
    end
  end

  // State, accumulators and the error pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      acc_q   <= INITS;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // Result register: a load in the same cycle as a take keeps valid high,
  // so back-to-back strings stream without a bubble.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_q     <= '0;
      res_len_q <= '0;
      res_vld_q <= 1'b0;
    end else if (load) begin
      res_q     <= acc_d;
      res_len_q <= len_d;
      res_vld_q <= 1'b1;
    end else if (s.res_ready_i) begin
      res_vld_q <= 1'b0;
    end
  end

endmodule
